// File: rtl/cpu_clock_ctrl.sv
`timescale 1ns/1ps
// cpu_clock_ctrl
//   Generates the CPU clock (oCLK) from CLOCK_50. There are two modes:
//     AUTO   : oCLK comes from a divider. The half-period is max(iFdiv,1) in
//              fast mode and SLOW_DIV in slow mode. KEY1 toggles fast/slow
//              and KEY2 enters MANUAL.
//     MANUAL : oCLK follows KEY3 (high while pressed). KEY1 and KEY2 toggle
//              the display page bits. KEY1+KEY2 together return to AUTO.
//   Keys are synchronized and then debounced. A press is a one-cycle event
//   on a released->pressed transition.
//
//   Build option: define CPU_CLOCK_CTRL_DEBOUNCE_EN to include the
//   DEB_CYCLES debounce. Without it, the debounced level is the
//   synchronized level.
//
// Ports
//   CLOCK_50       in   system clock (rising edge)
//   wRST           in   asynchronous reset, active-high
//   iKEY[2:0]      in   KEY3..KEY1, active-low, asynchronous
//   iFdiv[7:0]     in   fast-mode half-period in CLOCK_50 cycles (0 -> 1)
//   oCLK           out  CPU clock
//   oTick          out  one-cycle pulse when oCLK rises
//   oSelectManual  out  high in MANUAL
//   oSelectFast    out  fast/slow flag for AUTO
//   oDispSel[1:0]  out  display page select (00 in AUTO)
module cpu_clock_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned SLOW_DIV   = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       wRST,
    input  logic [2:0] iKEY,
    input  logic [7:0] iFdiv,
    output logic       oCLK,
    output logic       oTick,
    output logic       oSelectManual,
    output logic       oSelectFast,
    output logic [1:0] oDispSel
);
    localparam int unsigned CNT_MAX = (SLOW_DIV > 255) ? SLOW_DIV : 255;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {AUTO, MANUAL} state_t;

    logic [2:0]       sync1_q, sync2_q;
    logic [1:0]       sync_vld_q;
    logic [2:0]       deb_lvl;
    logic [2:0]       deb_prev_q;
    logic [2:0]       armed_q;
    logic [2:0]       press;

    state_t           state_q;
    logic             fast_q;
    logic             clk_q;
    logic             tick_q;
    logic             manual_q;
    logic [1:0]       disp_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       fdiv_q;
    logic [CNT_W-1:0] half_m1;

    // Two-flop synchronizer. The flops hold "released" during reset.
    // sync_vld_q marks when sync2_q holds a real sampled key level.
    always_ff @(posedge CLOCK_50 or posedge wRST) begin
        if (wRST) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            sync_vld_q <= '0;
        end else begin
            sync1_q    <= iKEY;
            sync2_q    <= sync1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

`ifdef CPU_CLOCK_CTRL_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    logic [2:0]       deb_lvl_q;
    logic [DEB_W-1:0] deb_cnt_q [3];

    // The counter counts consecutive cycles in which the synchronized level
    // differs from the debounced level. Any agreement resets the count.
    always_ff @(posedge CLOCK_50 or posedge wRST) begin
        if (wRST) begin
            deb_lvl_q <= '1;
            for (int unsigned i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2_q[i] == deb_lvl_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_lvl_q[i] <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    assign deb_lvl = deb_lvl_q;
`else
    logic deb_cycles_unused;

    assign deb_cycles_unused = (DEB_CYCLES != 0);
    assign deb_lvl           = sync2_q;
`endif

    // A key is armed only after it has been seen released since reset.
    // A key held through reset therefore gives no event until it is pressed again.
    always_ff @(posedge CLOCK_50 or posedge wRST) begin
        if (wRST) begin
            deb_prev_q <= '1;
            armed_q    <= '0;
        end else begin
            deb_prev_q <= deb_lvl;
            armed_q    <= armed_q | (sync2_q & {3{sync_vld_q[1]}});
        end
    end

    assign press = deb_prev_q & ~deb_lvl & armed_q;

    always_comb begin
        half_m1 = CNT_W'(SLOW_DIV - 1);
        if (fast_q) begin
            half_m1 = (iFdiv == 8'd0) ? '0 : CNT_W'(iFdiv) - CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge wRST) begin
        if (wRST) begin
            state_q  <= AUTO;
            fast_q   <= 1'b1;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            manual_q <= 1'b0;
            disp_q   <= '0;
            cnt_q    <= '0;
            fdiv_q   <= '0;
        end else begin
            fdiv_q <= iFdiv;
            tick_q <= 1'b0;
            case (state_q)
                AUTO: begin
                    if (press[1]) begin
                        state_q  <= MANUAL;
                        manual_q <= 1'b1;
                        clk_q    <= 1'b0;
                        cnt_q    <= '0;
                    end else if (press[0]) begin
                        fast_q <= ~fast_q;
                        cnt_q  <= '0;
                    end else if (iFdiv != fdiv_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q >= half_m1) begin
                        clk_q  <= ~clk_q;
                        tick_q <= ~clk_q;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                MANUAL: begin
                    cnt_q <= '0;
                    if (press[0] && press[1]) begin
                        state_q  <= AUTO;
                        manual_q <= 1'b0;
                        disp_q   <= '0;
                        clk_q    <= 1'b0;
                    end else begin
                        disp_q <= disp_q ^ press[1:0];
                        clk_q  <= ~deb_lvl[2];
                        tick_q <= ~deb_lvl[2] & ~clk_q;
                    end
                end
                default: state_q <= AUTO;
            endcase
        end
    end

    assign oCLK          = clk_q;
    assign oTick         = tick_q;
    assign oSelectManual = manual_q;
    assign oSelectFast   = fast_q;
    assign oDispSel      = disp_q;
endmodule

// File: doc/cpu_clock_ctrl.md
CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 500000: CLOCK_50 cycles a key level must stay stable before it is accepted (10 ms at 50 MHz).
REQ-002 Parameter SLOW_DIV, default 25000000: oCLK half-period, in CLOCK_50 cycles, in slow auto mode.
REQ-003 CLOCK_50  input  1  system clock; all state is on its rising edge.
REQ-004 wRST  input  1  reset, asynchronous, active-high.
REQ-005 iKEY  input  3  push buttons KEY[3:1], active-low, asynchronous to CLOCK_50.
REQ-006 iFdiv  input  8  fast-mode half-period in CLOCK_50 cycles; 0 is treated as 1.
REQ-007 oCLK  output  1  CPU clock.
REQ-008 oTick  output  1  one-cycle pulse in the CLOCK_50 cycle in which oCLK goes 0->1.
REQ-009 oSelectManual  output  1  high in MANUAL state.
REQ-010 oSelectFast  output  1  fast/slow flag for auto mode.
REQ-011 oDispSel  output  2  display page select.

Function
REQ-012 Each iKEY bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce: the debounced level SHALL update only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; releases generate no event.
REQ-015 State machine states are AUTO and MANUAL.
REQ-016 In AUTO, a KEY2 press event SHALL move to MANUAL and leave oSelectFast unchanged.
REQ-017 In AUTO, a KEY1 press event without a KEY2 press event SHALL toggle oSelectFast.
REQ-018 In AUTO, KEY2 has priority over KEY1 when both events occur in the same cycle.
REQ-019 In MANUAL, KEY1 and KEY2 press events in the same cycle SHALL return to AUTO and clear oDispSel to 00.
REQ-020 In MANUAL, a lone KEY1 event SHALL toggle oDispSel[0] and a lone KEY2 event SHALL toggle oDispSel[1].
REQ-021 oDispSel SHALL read 00 whenever the state is AUTO.
REQ-022 AUTO divider: a counter SHALL toggle oCLK when it reaches the half-period (max(iFdiv,1) when fast, SLOW_DIV when slow), then restart from 0.
REQ-023 A change of oSelectFast or of iFdiv SHALL restart the counter from 0 with oCLK unchanged.
REQ-024 MANUAL: oCLK SHALL equal the inverted debounced KEY3 level, so oCLK is high while the key is pressed.
REQ-025 MANUAL: the divider counter SHALL be held at 0.
REQ-026 Entering MANUAL SHALL force oCLK low in the same cycle.
REQ-027 Entering AUTO SHALL restart the divider with oCLK low.
REQ-028 KEY3 SHALL be ignored in AUTO.
REQ-029 oTick SHALL assert for exactly one cycle per oCLK rising transition in both states and never otherwise.

Reset
REQ-030 While wRST is high, all state SHALL clear immediately and asynchronously: state AUTO, oSelectFast=1, oCLK=0, oTick=0, oDispSel=00, oSelectManual=0, counters=0.
REQ-031 During reset, synchronizers and debounced levels SHALL hold released (1), so no press event fires on reset release.
REQ-032 A reset in mid half-period or during a held key SHALL abandon the operation; a key still held after reset produces no event until it is released and pressed again.

Configuration
REQ-033 Macro CPU_CLOCK_CTRL_DEBOUNCE_EN defined: debounce per REQ-013 is present.
REQ-034 Macro CPU_CLOCK_CTRL_DEBOUNCE_EN undefined: the debounced level SHALL equal the synchronized level (2-cycle latency, no counters) and DEB_CYCLES is unused; all other behaviour is identical.

Verification (DEB_CYCLES=4, SLOW_DIV=10, macro defined)
REQ-035 Reset then iFdiv=3 -> oCLK toggles every 3 cycles (period 6), one oTick per rise, oSelectFast=1, oDispSel=00.
REQ-036 KEY1 held low for 2 cycles, then released, then held low for 10 cycles -> no toggle from the short press; oSelectFast goes to 0 about 4 cycles after the long press becomes stable; oCLK period becomes 20.
REQ-037 KEY2 pressed -> MANUAL, oCLK=0 at once; KEY3 pressed then released -> oCLK follows each with debounce latency and gives exactly one oTick; KEY1 event -> oDispSel=01; KEY2 event -> 11.
REQ-038 In MANUAL, KEY1 and KEY2 released-to-pressed in the same cycle -> AUTO, oDispSel=00, divider restarts with oCLK low.
REQ-039 wRST pulsed mid half-period while KEY1 is held -> all outputs reach reset values asynchronously; no KEY1 event after release until a new press.
REQ-040 iFdiv=0 -> half-period 1 (oCLK toggles every cycle); iFdiv changed 3->5 mid-count -> counter restarts and the next toggle occurs 5 cycles later.
